// File: rtl/gpr_seq_pkg.sv
// Shared types and default sizes for the GPR operand read sequencer.
// Optional build macro: GPR_READ_ZERO_SKIP_EN (register index 0 reads as zero, no RAM access).
package gpr_seq_pkg;

   localparam int DEF_NUM_THREADS = 4;
   localparam int DEF_XLEN        = 32;
   localparam int DEF_NUM_WARPS   = 4;
   localparam int DEF_NUM_REGS    = 32;

   localparam int WID_BITS   = $clog2(DEF_NUM_WARPS);
   localparam int REG_BITS   = $clog2(DEF_NUM_REGS);
   localparam int RADDR_BITS = WID_BITS + REG_BITS;

`ifdef GPR_READ_ZERO_SKIP_EN
   localparam bit ZERO_SKIP = 1'b1;
`else
   localparam bit ZERO_SKIP = 1'b0;
`endif

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_RD_RS1 = 3'd1,
      ST_RD_RS2 = 3'd2,
      ST_RD_RS3 = 3'd3,
      ST_DRAIN  = 3'd4,
      ST_RSP    = 3'd5
   } seq_state_t;

   typedef enum logic [1:0] {
      TAG_NONE = 2'd0,
      TAG_RS1  = 2'd1,
      TAG_RS2  = 2'd2,
      TAG_RS3  = 2'd3
   } capture_tag_t;

endpackage

// File: rtl/gpr_read_sequencer_capture.sv
// Operand capture: tag register naming the operand whose RAM data arrives this
// cycle, plus the three per-thread operand registers (cleared on accept).
module gpr_operand_capture
   import gpr_seq_pkg::*;
#(
   parameter int NUM_THREADS = DEF_NUM_THREADS,
   parameter int XLEN        = DEF_XLEN
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        clear,
   input  logic [1:0]                  issue_tag,
   input  logic [NUM_THREADS*XLEN-1:0] rdata,
   output logic [NUM_THREADS*XLEN-1:0] rs1_data,
   output logic [NUM_THREADS*XLEN-1:0] rs2_data,
   output logic [NUM_THREADS*XLEN-1:0] rs3_data
);

   capture_tag_t tag;

   // Tag follows the address issued one cycle earlier, matching RAM latency.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tag <= TAG_NONE;
      end else begin
         tag <= capture_tag_t'(issue_tag);
      end
   end

   // Operand registers: cleared on accept, otherwise loaded from the RAM per tag.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rs1_data <= '0;
         rs2_data <= '0;
         rs3_data <= '0;
      end else if (clear) begin
         rs1_data <= '0;
         rs2_data <= '0;
         rs3_data <= '0;
      end else begin
         case (tag)
            TAG_RS1: rs1_data <= rdata;
            TAG_RS2: rs2_data <= rdata;
            TAG_RS3: rs3_data <= rdata;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/gpr_read_sequencer.sv
// GPR operand read sequencer: fetches rs1, rs2 and optionally rs3 of one issued
// instruction through a single-read-port banked register file RAM and presents
// them as one response bundle.
// Optional build macro: GPR_READ_ZERO_SKIP_EN (operands with index 0 are not
// read and return zero lanes; their read states are skipped).
//
// state   | meaning
// IDLE    | waiting for a request
// RD_RS1  | rs1 address on the RAM port
// RD_RS2  | rs2 address on the RAM port
// RD_RS3  | rs3 address on the RAM port
// DRAIN   | last read data returning, captured this cycle
// RSP     | bundle presented, waiting for rsp_ready
module gpr_read_sequencer
   import gpr_seq_pkg::*;
#(
   parameter int NUM_THREADS = DEF_NUM_THREADS,
   parameter int XLEN        = DEF_XLEN,
   parameter int NUM_WARPS   = DEF_NUM_WARPS,
   parameter int NUM_REGS    = DEF_NUM_REGS
) (
   input  logic                                         clk,
   input  logic                                         reset_n,
   input  logic                                         req_valid,
   output logic                                         req_ready,
   input  logic [$clog2(NUM_WARPS)-1:0]                 req_wid,
   input  logic [$clog2(NUM_REGS)-1:0]                  req_rs1,
   input  logic [$clog2(NUM_REGS)-1:0]                  req_rs2,
   input  logic [$clog2(NUM_REGS)-1:0]                  req_rs3,
   input  logic                                         req_use_rs3,
   output logic                                         rf_rden,
   output logic [$clog2(NUM_WARPS)+$clog2(NUM_REGS)-1:0] rf_raddr,
   input  logic [NUM_THREADS*XLEN-1:0]                  rf_rdata,
   output logic                                         rsp_valid,
   input  logic                                         rsp_ready,
   output logic [$clog2(NUM_WARPS)-1:0]                 rsp_wid,
   output logic [NUM_THREADS*XLEN-1:0]                  rsp_rs1_data,
   output logic [NUM_THREADS*XLEN-1:0]                  rsp_rs2_data,
   output logic [NUM_THREADS*XLEN-1:0]                  rsp_rs3_data
);

   localparam int WB = $clog2(NUM_WARPS);
   localparam int RB = $clog2(NUM_REGS);

   seq_state_t      state;
   seq_state_t      state_nx;
   seq_state_t      first_rd;
   seq_state_t      rd_after_rs1;
   seq_state_t      rd_after_rs2;
   capture_tag_t    issue_tag;

   logic [WB-1:0]    wid_q;
   logic [RB-1:0]    rs1_q;
   logic [RB-1:0]    rs2_q;
   logic [RB-1:0]    rs3_q;
   logic             use_rs3_q;

   logic [WB-1:0]    wid_sel;
   logic [RB-1:0]    rs1_sel;
   logic [RB-1:0]    rs2_sel;
   logic [RB-1:0]    rs3_sel;
   logic             use_rs3_sel;
   logic [WB+RB-1:0] raddr_nx;
   logic             accept;

   // With zero-skip, index 0 is a hardwired zero and never touches the RAM.
   function automatic logic needs_read(input logic [RB-1:0] idx);
      return (ZERO_SKIP == 1'b0) || (idx != '0);
   endfunction

   assign req_ready = (state == ST_IDLE) | ((state == ST_RSP) & rsp_ready);
   assign accept    = req_valid & req_ready;
   assign rsp_wid   = wid_q;

   // A request accepted this cycle steers the next addresses directly.
   assign wid_sel     = accept ? req_wid     : wid_q;
   assign rs1_sel     = accept ? req_rs1     : rs1_q;
   assign rs2_sel     = accept ? req_rs2     : rs2_q;
   assign rs3_sel     = accept ? req_rs3     : rs3_q;
   assign use_rs3_sel = accept ? req_use_rs3 : use_rs3_q;

   // Next read chain and FSM next state.
   always_comb begin
      rd_after_rs2 = (use_rs3_sel && needs_read(rs3_sel)) ? ST_RD_RS3 : ST_DRAIN;
      rd_after_rs1 = needs_read(rs2_sel) ? ST_RD_RS2 : rd_after_rs2;
      if (needs_read(rs1_sel)) begin
         first_rd = ST_RD_RS1;
      end else if (rd_after_rs1 == ST_DRAIN) begin
         first_rd = ST_RSP;
      end else begin
         first_rd = rd_after_rs1;
      end

      state_nx = state;
      case (state)
         ST_IDLE:   if (accept) state_nx = first_rd;
         ST_RD_RS1: state_nx = rd_after_rs1;
         ST_RD_RS2: state_nx = rd_after_rs2;
         ST_RD_RS3: state_nx = ST_DRAIN;
         ST_DRAIN:  state_nx = ST_RSP;
         ST_RSP:    if (rsp_ready) state_nx = accept ? first_rd : ST_IDLE;
         default:   state_nx = ST_IDLE;
      endcase
   end

   // RAM address for the upcoming read state, and capture tag for the current one.
   always_comb begin
      raddr_nx = rf_raddr;
      case (state_nx)
         ST_RD_RS1: raddr_nx = {wid_sel, rs1_sel};
         ST_RD_RS2: raddr_nx = {wid_sel, rs2_sel};
         ST_RD_RS3: raddr_nx = {wid_sel, rs3_sel};
         default:   raddr_nx = rf_raddr;
      endcase

      case (state)
         ST_RD_RS1: issue_tag = TAG_RS1;
         ST_RD_RS2: issue_tag = TAG_RS2;
         ST_RD_RS3: issue_tag = TAG_RS3;
         default:   issue_tag = TAG_NONE;
      endcase
   end

   // FSM state with registered RAM strobe/address and response valid.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         rf_rden   <= 1'b0;
         rf_raddr  <= '0;
         rsp_valid <= 1'b0;
      end else begin
         state     <= state_nx;
         rf_rden   <= (state_nx == ST_RD_RS1) || (state_nx == ST_RD_RS2) ||
                      (state_nx == ST_RD_RS3);
         rf_raddr  <= raddr_nx;
         rsp_valid <= (state_nx == ST_RSP);
      end
   end

   // Request fields held for the whole sequence.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wid_q     <= '0;
         rs1_q     <= '0;
         rs2_q     <= '0;
         rs3_q     <= '0;
         use_rs3_q <= 1'b0;
      end else if (accept) begin
         wid_q     <= req_wid;
         rs1_q     <= req_rs1;
         rs2_q     <= req_rs2;
         rs3_q     <= req_rs3;
         use_rs3_q <= req_use_rs3;
      end
   end

   gpr_operand_capture #(
      .NUM_THREADS (NUM_THREADS),
      .XLEN        (XLEN)
   ) u_capture (
      .clk       (clk),
      .reset_n   (reset_n),
      .clear     (accept),
      .issue_tag (issue_tag),
      .rdata     (rf_rdata),
      .rs1_data  (rsp_rs1_data),
      .rs2_data  (rsp_rs2_data),
      .rs3_data  (rsp_rs3_data)
   );

endmodule

// File: tb/tb_gpr_read_sequencer.sv
// Self-checking bench for gpr_read_sequencer: RAM model, read-address and
// response scoreboards, directed request sequences.
module tb_gpr_read_sequencer;

   localparam int NT = 4;
   localparam int XL = 32;
   localparam int WB = 2;
   localparam int RB = 5;
   localparam int DW = NT * XL;

`ifdef GPR_READ_ZERO_SKIP_EN
   localparam bit SKIP = 1'b1;
`else
   localparam bit SKIP = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             reset_n = 1'b1;
   logic             req_valid = 1'b0;
   logic             req_ready;
   logic [WB-1:0]    req_wid = '0;
   logic [RB-1:0]    req_rs1 = '0;
   logic [RB-1:0]    req_rs2 = '0;
   logic [RB-1:0]    req_rs3 = '0;
   logic             req_use_rs3 = 1'b0;
   logic             rf_rden;
   logic [WB+RB-1:0] rf_raddr;
   logic [DW-1:0]    rf_rdata = '0;
   logic             rsp_valid;
   logic             rsp_ready = 1'b1;
   logic [WB-1:0]    rsp_wid;
   logic [DW-1:0]    rsp_rs1_data;
   logic [DW-1:0]    rsp_rs2_data;
   logic [DW-1:0]    rsp_rs3_data;

   always #5 clk = ~clk;

   gpr_read_sequencer dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_wid      (req_wid),
      .req_rs1      (req_rs1),
      .req_rs2      (req_rs2),
      .req_rs3      (req_rs3),
      .req_use_rs3  (req_use_rs3),
      .rf_rden      (rf_rden),
      .rf_raddr     (rf_raddr),
      .rf_rdata     (rf_rdata),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_wid      (rsp_wid),
      .rsp_rs1_data (rsp_rs1_data),
      .rsp_rs2_data (rsp_rs2_data),
      .rsp_rs3_data (rsp_rs3_data)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Lane l of register r holds r*16 + l.
   function automatic logic [DW-1:0] lanes_of(input logic [RB-1:0] r);
      logic [DW-1:0] v;
      v = '0;
      for (int l = 0; l < NT; l++) v[l*XL +: XL] = 32'(r) * 32'd16 + 32'(l);
      return v;
   endfunction

   function automatic bit needs(input logic [RB-1:0] r);
      return !SKIP || (r != '0);
   endfunction

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Register file RAM: one-cycle read latency, junk when not reading.
   always @(posedge clk) begin
      if (rf_rden) rf_rdata <= lanes_of(rf_raddr[RB-1:0]);
      else         rf_rdata <= {NT{32'hBAD0_0BAD}};
   end

   typedef struct {
      logic [WB-1:0] wid;
      logic [DW-1:0] d1;
      logic [DW-1:0] d2;
      logic [DW-1:0] d3;
      int unsigned   rsp_cyc;
   } bundle_t;

   typedef struct {
      logic [WB+RB-1:0] addr;
      int unsigned      cyc;
   } rd_t;

   bundle_t bq[$];
   rd_t     rq[$];

   // Scoreboard monitor, sampled on the falling edge.
   always @(negedge clk) begin
      bit            exp_valid;
      bit            exp_ready;
      bit            exp_rden;
      bundle_t       b;
      rd_t           r;
      int            n;
      logic [RB-1:0] ops [3];
      if (!reset_n) begin
         bq.delete();
         rq.delete();
      end else begin
         exp_valid = (bq.size() > 0) && (cyc >= bq[0].rsp_cyc);
         exp_ready = (bq.size() == 0) || (exp_valid && rsp_ready);
         check("rsp_valid", DW'(rsp_valid), DW'(exp_valid));
         check("req_ready", DW'(req_ready), DW'(exp_ready));
         if (exp_valid) begin
            check("rsp_wid", DW'(rsp_wid), DW'(bq[0].wid));
            check("rsp_rs1", rsp_rs1_data, bq[0].d1);
            check("rsp_rs2", rsp_rs2_data, bq[0].d2);
            check("rsp_rs3", rsp_rs3_data, bq[0].d3);
            if (rsp_ready) void'(bq.pop_front());
         end

         exp_rden = (rq.size() > 0) && (rq[0].cyc == cyc);
         check("rf_rden", DW'(rf_rden), DW'(exp_rden));
         if (exp_rden) begin
            check("rf_raddr", DW'(rf_raddr), DW'(rq[0].addr));
         end
         while (rq.size() > 0 && rq[0].cyc <= cyc) void'(rq.pop_front());

         if (req_valid && exp_ready) begin
            ops[0] = req_rs1;
            ops[1] = req_rs2;
            ops[2] = req_rs3;
            n = 0;
            for (int i = 0; i < 3; i++) begin
               if ((i < 2 || req_use_rs3) && needs(ops[i])) begin
                  r.addr = {req_wid, ops[i]};
                  r.cyc  = cyc + 1 + n;
                  rq.push_back(r);
                  n++;
               end
            end
            b.wid     = req_wid;
            b.d1      = needs(req_rs1) ? lanes_of(req_rs1) : '0;
            b.d2      = needs(req_rs2) ? lanes_of(req_rs2) : '0;
            b.d3      = (req_use_rs3 && needs(req_rs3)) ? lanes_of(req_rs3) : '0;
            b.rsp_cyc = cyc + ((n == 0) ? 1 : n + 2);
            bq.push_back(b);
         end
      end
   end

   task automatic send(input logic [WB-1:0] w, input logic [RB-1:0] a, input logic [RB-1:0] b2,
                       input logic [RB-1:0] c, input logic u3);
      int k;
      req_wid     = w;
      req_rs1     = a;
      req_rs2     = b2;
      req_rs3     = c;
      req_use_rs3 = u3;
      req_valid   = 1'b1;
      k = 0;
      @(negedge clk);
      while (!req_ready && k < 100) begin
         @(negedge clk);
         k++;
      end
      if (!req_ready) check("accept_timeout", DW'(req_ready), DW'(1));
      @(posedge clk);
      #1 req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 100 && bq.size() != 0; i++) @(negedge clk);
      if (bq.size() != 0) check("drain_timeout", DW'(bq.size()), DW'(0));
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string pfx);
      check({pfx, "_req_ready"}, DW'(req_ready), DW'(1));
      check({pfx, "_rf_rden"},   DW'(rf_rden),   DW'(0));
      check({pfx, "_rf_raddr"},  DW'(rf_raddr),  DW'(0));
      check({pfx, "_rsp_valid"}, DW'(rsp_valid), DW'(0));
      check({pfx, "_rsp_wid"},   DW'(rsp_wid),   DW'(0));
      check({pfx, "_rs1"},       rsp_rs1_data,   DW'(0));
      check({pfx, "_rs2"},       rsp_rs2_data,   DW'(0));
      check({pfx, "_rs3"},       rsp_rs3_data,   DW'(0));
   endtask

   initial begin
      #1 reset_n = 1'b0;
      #2 check_reset_outputs("reset");
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;

      // Basic two-operand read, then three operands.
      rsp_ready = 1'b1;
      send(2'd2, 5'd5, 5'd7, 5'd9, 1'b0);
      wait_idle();
      send(2'd1, 5'd4, 5'd6, 5'd9, 1'b1);
      wait_idle();

      // Backpressure: response held six cycles while the next request waits.
      rsp_ready = 1'b0;
      send(2'd3, 5'd10, 5'd11, 5'd12, 1'b0);
      fork
         send(2'd0, 5'd13, 5'd14, 5'd15, 1'b1);
         begin
            int k;
            k = 0;
            @(negedge clk);
            while (!rsp_valid && k < 50) begin
               @(negedge clk);
               k++;
            end
            repeat (6) @(negedge clk);
            @(posedge clk);
            #1 rsp_ready = 1'b1;
         end
      join
      wait_idle();

      // Reset asserted while rs2 address is on the RAM port.
      send(2'd1, 5'd20, 5'd21, 5'd22, 1'b1);
      @(posedge clk);
      #3 reset_n = 1'b0;
      #1 check_reset_outputs("midrst");
      @(posedge clk);
      #1 reset_n = 1'b1;
      repeat (8) @(negedge clk);
      check("post_rst_rs1", rsp_rs1_data, DW'(0));
      check("post_rst_rs2", rsp_rs2_data, DW'(0));
      check("post_rst_rs3", rsp_rs3_data, DW'(0));
      @(posedge clk);
      #1;

      // Back-to-back requests with the consumer always ready.
      for (int i = 0; i < 4; i++) begin
         send(2'(i), 5'(3 + i), 5'(17 + i), 5'(25 + i), 1'b0);
      end
      wait_idle();

      // Register index zero operands.
      send(2'd0, 5'd0, 5'd0, 5'd0, 1'b0);
      wait_idle();
      send(2'd2, 5'd0, 5'd3, 5'd0, 1'b0);
      wait_idle();
      send(2'd3, 5'd0, 5'd0, 5'd31, 1'b1);
      wait_idle();
      send(2'd1, 5'd8, 5'd0, 5'd0, 1'b1);
      wait_idle();

      repeat (4) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
